// File: rtl/dtcm_port_arbiter_pkg.sv
// Shared constants for the DTCM port arbiter: read-owner tag values and tag FIFO depth.
package dtcm_port_arbiter_pkg;
    localparam logic DTCM_ARB_TAG_CORE   = 1'b0;
    localparam logic DTCM_ARB_TAG_SYS    = 1'b1;
    localparam int   DTCM_ARB_FIFO_DEPTH = 2;
endpackage

// File: rtl/dtcm_port_arbiter_tag_fifo.sv
// dtcm_arb_tag_fifo: 2-entry, 1-bit owner-tag FIFO tracking outstanding DTCM reads in issue order.
module dtcm_arb_tag_fifo
    import dtcm_port_arbiter_pkg::*;
(
    input  logic       cpu_clk,
    input  logic       cpu_rstn,
    input  logic       push,
    input  logic       push_tag,
    input  logic       pop,
    output logic       head_tag,
    output logic [1:0] count,
    output logic       can_push
);
    localparam logic [1:0] FULL = 2'(DTCM_ARB_FIFO_DEPTH);

    logic [DTCM_ARB_FIFO_DEPTH-1:0] tags;
    logic wr_ptr;
    logic rd_ptr;
    logic do_push;
    logic do_pop;

    // A pop on an empty FIFO is a stray return and is ignored; a pop frees a slot for a same-cycle push.
    assign do_pop   = pop && (count != 2'd0);
    assign can_push = (count < FULL) || do_pop;
    assign do_push  = push && can_push;
    assign head_tag = tags[rd_ptr];

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push)
                wr_ptr <= ~wr_ptr;
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            if (do_push && !do_pop)
                count <= count + 2'd1;
            else if (do_pop && !do_push)
                count <= count - 2'd1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (do_push)
            tags[wr_ptr] <= push_tag;
    end
endmodule

// File: rtl/dtcm_port_arbiter.sv
// Shares the DTCM port between the core data path and the system slave port; routes read returns in order.
// Optional fair mode (sys anti-starvation) is enabled by defining KRV_DTCM_ARB_FAIR_EN.
module dtcm_port_arbiter
    import dtcm_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  core_access,
    input  logic                  core_rd0_wr1,
    input  logic [3:0]            core_byte_strobe,
    input  logic [DATA_WIDTH-1:0] core_write_data,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    output logic                  core_ready,
    output logic [DATA_WIDTH-1:0] core_read_data,
    output logic                  core_read_data_valid,
    input  logic                  sys_access,
    input  logic                  sys_rd0_wr1,
    input  logic [3:0]            sys_byte_strobe,
    input  logic [DATA_WIDTH-1:0] sys_write_data,
    input  logic [ADDR_WIDTH-1:0] sys_addr,
    output logic                  sys_ready,
    output logic [DATA_WIDTH-1:0] sys_read_data,
    output logic                  sys_read_data_valid,
    output logic                  dtcm_access,
    output logic                  dtcm_rd0_wr1,
    output logic [3:0]            dtcm_byte_strobe,
    output logic [DATA_WIDTH-1:0] dtcm_write_data,
    output logic [ADDR_WIDTH-1:0] dtcm_addr,
    input  logic                  dtcm_ready,
    input  logic [DATA_WIDTH-1:0] dtcm_read_data,
    input  logic                  dtcm_read_data_valid
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("dtcm_port_arbiter: STARVE_LIMIT must be within 1..15");
    end

    logic       pop;
    logic       push;
    logic       push_tag;
    logic       head_tag;
    logic       can_push;
    logic [1:0] fifo_count;
    logic       ret_valid;
    logic       core_elig;
    logic       sys_elig;
    logic       core_win;
    logic       sys_win;

    // Every request and return is qualified with cpu_rstn so all outputs read 0 while reset is held.
    assign pop       = cpu_rstn && dtcm_read_data_valid;
    assign core_elig = cpu_rstn && core_access && dtcm_ready && (core_rd0_wr1 || can_push);
    assign sys_elig  = cpu_rstn && sys_access && dtcm_ready && (sys_rd0_wr1 || can_push);
    assign sys_win   = sys_elig && !core_win;

`ifdef KRV_DTCM_ARB_FAIR_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       force_sys;

    assign core_win = core_elig && !(force_sys && sys_elig);

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            starve_cnt <= 4'd0;
            force_sys  <= 1'b0;
        end else if (sys_win) begin
            starve_cnt <= 4'd0;
            force_sys  <= 1'b0;
        end else if (sys_elig && core_win && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
            if (starve_cnt + 4'd1 == LIMIT)
                force_sys <= 1'b1;
        end
    end
`else
    assign core_win = core_elig;
`endif

    assign core_ready = core_win;
    assign sys_ready  = sys_win;
    assign push       = (core_win && !core_rd0_wr1) || (sys_win && !sys_rd0_wr1);
    assign push_tag   = sys_win ? DTCM_ARB_TAG_SYS : DTCM_ARB_TAG_CORE;

    dtcm_arb_tag_fifo u_tag_fifo (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head_tag (head_tag),
        .count    (fifo_count),
        .can_push (can_push)
    );

    always_comb begin
        dtcm_access      = 1'b0;
        dtcm_rd0_wr1     = 1'b0;
        dtcm_byte_strobe = 4'd0;
        dtcm_write_data  = '0;
        dtcm_addr        = '0;
        if (core_win) begin
            dtcm_access      = 1'b1;
            dtcm_rd0_wr1     = core_rd0_wr1;
            dtcm_byte_strobe = core_byte_strobe;
            dtcm_write_data  = core_write_data;
            dtcm_addr        = core_addr;
        end else if (sys_win) begin
            dtcm_access      = 1'b1;
            dtcm_rd0_wr1     = sys_rd0_wr1;
            dtcm_byte_strobe = sys_byte_strobe;
            dtcm_write_data  = sys_write_data;
            dtcm_addr        = sys_addr;
        end
    end

    // Returns with no tag outstanding are dropped rather than routed to either port.
    assign ret_valid            = pop && (fifo_count != 2'd0);
    assign core_read_data_valid = ret_valid && (head_tag == DTCM_ARB_TAG_CORE);
    assign sys_read_data_valid  = ret_valid && (head_tag == DTCM_ARB_TAG_SYS);
    assign core_read_data       = core_read_data_valid ? dtcm_read_data : '0;
    assign sys_read_data        = sys_read_data_valid ? dtcm_read_data : '0;
endmodule
